// File: rtl/demux_32_stream.sv
// demux_32_stream: steers each input word to one of two FIFO-buffered output ports by in_sel.
// Latency: 1 cycle from input accept to outk_valid; no combinational input-to-output path.
// Backpressure: in_ready drops while the FIFO chosen by in_sel is full; each port drains independently.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_sel/in_data   producer stream; in_sel picks port 0 or 1
//   outk_valid/outk_ready/outk_data    consumer stream k; data is zero when empty
//   outk_level                    occupancy of port k FIFO, 0..DEPTH

// Per-port storage: circular buffer with a separate level counter.
// Latency: a pushed word is visible on data/valid the cycle after the push edge.
// Backpressure: pushes are ignored while full (even if popping), pops ignored while empty.
module demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [0:WIDTH-1] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [0:WIDTH-1] data,
  output logic [CW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the stored level alone, so a pop in the same cycle
  // never opens a slot for the incoming word.
  assign full    = (level == CW'(DEPTH));
  assign valid   = (level != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  // Head word is masked to zero when empty so stale storage never leaks out.
  assign data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observable through the level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

module demux_32_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  // Derived from DEPTH; not meant to be overridden.
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [0:WIDTH-1] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [0:WIDTH-1] out0_data,
  output logic [CW-1:0]    out0_level,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [0:WIDTH-1] out1_data,
  output logic [CW-1:0]    out1_level
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  // Depends only on in_sel and stored state, never on in_valid or the
  // consumer readies, so there is no combinational loop through the handshake.
  assign in_ready = !rst && !(in_sel ? full1 : full0);

  assign push0 = in_valid && in_ready && !in_sel;
  assign push1 = in_valid && in_ready &&  in_sel;
  assign pop0  = out0_valid && out0_ready;
  assign pop1  = out1_valid && out1_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .valid     (out0_valid),
    .data      (out0_data),
    .level     (out0_level)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .valid     (out1_valid),
    .data      (out1_data),
    .level     (out1_level)
  );

endmodule

// File: tb/tb_demux_32_stream.sv
// Bench for demux_32_stream: directed cases with literal expectations plus
// a randomized run against a queue-based model of the two ports.
module tb_demux_32_stream;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_sel = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out0_ready = 1'b0;
  logic             out1_ready = 1'b0;
  logic             in_ready;
  logic             out0_valid;
  logic             out1_valid;
  logic [WIDTH-1:0] out0_data;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out0_level;
  logic [CW-1:0]    out1_level;

  int total = 0;
  int bad   = 0;

  // Model: one queue of words per port.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  bit model_ok   = 1'b0;
  bit last_stall = 1'b0;

  demux_32_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_level (out0_level),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_level (out1_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare against the model mid-cycle, then advance the model using the
  // inputs that will be sampled at the coming rising edge.
  always @(negedge clk) begin
    int n0;
    int n1;
    logic exp_rdy;
    logic push;
    logic [WIDTH-1:0] h0;
    logic [WIDTH-1:0] h1;
    n0 = q0.size();
    n1 = q1.size();
    exp_rdy = !rst && ((in_sel ? n1 : n0) < DEPTH);
    if (model_ok) begin
      h0 = '0;
      h1 = '0;
      if (n0 > 0) h0 = q0[0];
      if (n1 > 0) h1 = q1[0];
      chk("m_out0_valid", WIDTH'(out0_valid), WIDTH'(n0 != 0));
      chk("m_out0_data",  out0_data, h0);
      chk("m_out0_level", WIDTH'(out0_level), WIDTH'(n0));
      chk("m_out1_valid", WIDTH'(out1_valid), WIDTH'(n1 != 0));
      chk("m_out1_data",  out1_data, h1);
      chk("m_out1_level", WIDTH'(out1_level), WIDTH'(n1));
      chk("m_in_ready",   WIDTH'(in_ready), WIDTH'(exp_rdy));
    end
    last_stall = !rst && in_valid && !exp_rdy;
    if (rst) begin
      q0.delete();
      q1.delete();
      model_ok = 1'b1;
    end else begin
      push = in_valid && exp_rdy;
      if (out0_ready && n0 > 0) void'(q0.pop_front());
      if (out1_ready && n1 > 0) void'(q1.pop_front());
      if (push) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  initial begin
    // Reset held for two edges.
    tick();
    chk("rst_valid0", WIDTH'(out0_valid), 0);
    chk("rst_valid1", WIDTH'(out1_valid), 0);
    chk("rst_data0",  out0_data, 0);
    chk("rst_data1",  out1_data, 0);
    chk("rst_level0", WIDTH'(out0_level), 0);
    chk("rst_level1", WIDTH'(out1_level), 0);
    tick();
    chk("rst_in_ready", WIDTH'(in_ready), 0);
    rst = 1'b0;
    in_sel = 1'b0;
    #1 chk("idle_rdy_sel0", WIDTH'(in_ready), 1);
    in_sel = 1'b1;
    #1 chk("idle_rdy_sel1", WIDTH'(in_ready), 1);

    // Single route to port 1.
    tick();
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hDEADBEEF; out1_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("route_valid1", WIDTH'(out1_valid), 1);
    chk("route_data1",  out1_data, 32'hDEADBEEF);
    chk("route_level1", WIDTH'(out1_level), 1);
    chk("route_valid0", WIDTH'(out0_valid), 0);
    tick();
    chk("route_drained1", WIDTH'(out1_level), 0);
    chk("route_valid0b",  WIDTH'(out0_valid), 0);
    out1_ready = 1'b0;

    // Fill port 0 and stall it; port 1 still accepts.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11111111;
    tick();
    in_data = 32'h22222222;
    tick();
    in_valid = 1'b0;
    chk("fill_level0", WIDTH'(out0_level), 2);
    chk("fill_rdy_sel0", WIDTH'(in_ready), 0);
    in_sel = 1'b1;
    #1 chk("fill_rdy_sel1", WIDTH'(in_ready), 1);
    in_valid = 1'b1; in_data = 32'h33333333;
    tick();
    in_valid = 1'b0;
    chk("fill_level1", WIDTH'(out1_level), 1);
    chk("fill_data1",  out1_data, 32'h33333333);
    chk("fill_level0b", WIDTH'(out0_level), 2);
    out0_ready = 1'b1;
    chk("drain_first", out0_data, 32'h11111111);
    tick();
    chk("drain_second", out0_data, 32'h22222222);
    chk("drain_level",  WIDTH'(out0_level), 1);
    tick();
    chk("drain_empty", WIDTH'(out0_valid), 0);
    chk("drain_zero",  out0_data, 0);
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;

    // Full FIFO with a simultaneous pop: push refused, accepted next cycle.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA0000001;
    tick();
    in_data = 32'hA0000002;
    tick();
    in_data = 32'hA0000003;
    out0_ready = 1'b1;
    #1 chk("fullpop_rdy", WIDTH'(in_ready), 0);
    tick();
    chk("fullpop_level", WIDTH'(out0_level), 1);
    chk("fullpop_head",  out0_data, 32'hA0000002);
    chk("fullpop_rdy2",  WIDTH'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("fullpop_level2", WIDTH'(out0_level), 1);
    chk("fullpop_head2",  out0_data, 32'hA0000003);
    tick();
    chk("fullpop_empty", WIDTH'(out0_level), 0);
    out0_ready = 1'b0;

    // Wrap-around on port 1: alternate push and pop for 10 words.
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = WIDTH'(i);
      tick();
      in_valid = 1'b0;
      chk("wrap_data",  out1_data, WIDTH'(i));
      chk("wrap_level", WIDTH'(out1_level), 1);
      out1_ready = 1'b1;
      tick();
      out1_ready = 1'b0;
      chk("wrap_empty", WIDTH'(out1_level), 0);
    end

    // Reset with both FIFOs full discards everything.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hB0000001;
    tick();
    in_data = 32'hB0000002;
    tick();
    in_sel = 1'b1; in_data = 32'hB0000003;
    tick();
    in_data = 32'hB0000004;
    tick();
    in_valid = 1'b0;
    chk("mid_level0", WIDTH'(out0_level), 2);
    chk("mid_level1", WIDTH'(out1_level), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_level0", WIDTH'(out0_level), 0);
    chk("midrst_level1", WIDTH'(out1_level), 0);
    chk("midrst_valid0", WIDTH'(out0_valid), 0);
    chk("midrst_valid1", WIDTH'(out1_valid), 0);
    chk("midrst_data0",  out0_data, 0);
    chk("midrst_data1",  out1_data, 0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hC0000000;
    tick();
    in_valid = 1'b0;
    chk("midrst_new_data",  out0_data, 32'hC0000000);
    chk("midrst_new_level", WIDTH'(out0_level), 1);
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;

    // Randomized traffic; first phase starves consumers to exercise full.
    for (int c = 0; c < 3000; c++) begin
      if (!last_stall) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = $urandom();
      end
      if (c < 1000) begin
        out0_ready = ($urandom_range(0, 3) == 0);
        out1_ready = ($urandom_range(0, 3) == 0);
      end else begin
        out0_ready = ($urandom_range(0, 3) != 0);
        out1_ready = ($urandom_range(0, 1) != 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
